// File: rtl/line_fill_engine.sv
// Line fill / write-back sequencer: splits one cache-line request into word
// transfers on the peripherals io channel and reports completion with one pulse.
module line_fill_engine #(
  parameter int         XLEN           = 32,
  parameter int         LINE_BYTES     = 32,
  parameter logic [1:0] IO_WORD_SIZE   = 2'd0,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    line_read_en,
  input  logic                    line_write_en,
  input  logic [XLEN-1:0]         line_addr,
  input  logic [LINE_BYTES*8-1:0] line_wdata,
  output logic [LINE_BYTES*8-1:0] line_rdata,
  output logic                    line_ready,
  output logic                    line_err,
  output logic                    line_busy,
  output logic [XLEN-1:0]         io_addr,
  output logic                    io_read,
  output logic                    io_write,
  output logic [XLEN-1:0]         io_wdata,
  output logic [1:0]              io_byte_size,
  input  logic [XLEN-1:0]         io_rdata,
  input  logic                    io_ready
);

  localparam int WB  = XLEN / 8;
  localparam int N   = LINE_BYTES / WB;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int WBS = $clog2(WB);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    is_wr_q, is_wr_d;
  logic                    err_q, err_d;
  logic [XLEN-1:0]         base_q, base_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic [N-1:0][XLEN-1:0]  wbuf_q, wbuf_d;
  logic [N-1:0][XLEN-1:0]  rdata_q, rdata_d;
  logic [XLEN-1:0]         io_addr_q, io_addr_d;
  logic                    io_read_q, io_read_d;
  logic                    io_write_q, io_write_d;
  logic [XLEN-1:0]         io_wdata_q, io_wdata_d;
  logic [1:0]              io_size_q, io_size_d;

  logic [XLEN-1:0]         idx_ext;
  logic [XLEN-1:0]         word_addr;

  assign idx_ext   = XLEN'(idx_q);
  assign word_addr = base_q + (idx_ext << WBS);

  // State register (all sequential state lives here)
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      is_wr_q    <= 1'b0;
      err_q      <= 1'b0;
      base_q     <= '0;
      idx_q      <= '0;
      tcnt_q     <= '0;
      wbuf_q     <= '0;
      rdata_q    <= '0;
      io_addr_q  <= '0;
      io_read_q  <= 1'b0;
      io_write_q <= 1'b0;
      io_wdata_q <= '0;
      io_size_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      err_q      <= err_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      tcnt_q     <= tcnt_d;
      wbuf_q     <= wbuf_d;
      rdata_q    <= rdata_d;
      io_addr_q  <= io_addr_d;
      io_read_q  <= io_read_d;
      io_write_q <= io_write_d;
      io_wdata_q <= io_wdata_d;
      io_size_q  <= io_size_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    err_d      = err_q;
    base_d     = base_q;
    idx_d      = idx_q;
    tcnt_d     = tcnt_q;
    wbuf_d     = wbuf_q;
    rdata_d    = rdata_q;
    io_addr_d  = io_addr_q;
    io_read_d  = io_read_q;
    io_write_d = io_write_q;
    io_wdata_d = io_wdata_q;
    io_size_d  = io_size_q;

    case (state_q)
      IDLE: begin
        if (line_write_en || line_read_en) begin
          state_d = ISSUE;
          is_wr_d = line_write_en;
          err_d   = 1'b0;
          idx_d   = '0;
          base_d  = line_addr & ~XLEN'(LINE_BYTES - 1);
          if (line_write_en) begin
            wbuf_d = line_wdata;
          end
        end
      end
      // Strobes are registered, so the ISSUE cycle is the strobe-low gap
      ISSUE: begin
        io_addr_d  = word_addr;
        io_size_d  = IO_WORD_SIZE;
        io_read_d  = !is_wr_q;
        io_write_d = is_wr_q;
        io_wdata_d = is_wr_q ? wbuf_q[idx_q] : '0;
        tcnt_d     = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (io_ready) begin
          if (!is_wr_q) begin
            rdata_d[idx_q] = io_rdata;
          end
          io_read_d  = 1'b0;
          io_write_d = 1'b0;
          if (idx_q == IW'(N - 1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ISSUE;
          end
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          io_read_d  = 1'b0;
          io_write_d = 1'b0;
          err_d      = 1'b1;
          state_d    = DONE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    line_busy    = (state_q != IDLE);
    line_ready   = (state_q == DONE);
    line_err     = (state_q == DONE) && err_q;
    line_rdata   = rdata_q;
    io_addr      = io_addr_q;
    io_read      = io_read_q;
    io_write     = io_write_q;
    io_wdata     = io_wdata_q;
    io_byte_size = io_size_q;
  end

endmodule

// File: tb/tb_line_fill_engine.sv
// Directed bench for line_fill_engine with an io responder of programmable latency.
module tb_line_fill_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read_en, line_write_en;
  logic [31:0]  line_addr;
  logic [255:0] line_wdata, line_rdata;
  logic         line_ready, line_err, line_busy;
  logic [31:0]  io_addr, io_wdata, io_rdata;
  logic         io_read, io_write, io_ready;
  logic [1:0]   io_byte_size;

  always #5 clk = ~clk;

  line_fill_engine dut (
    .clk(clk), .rst(rst),
    .line_read_en(line_read_en), .line_write_en(line_write_en),
    .line_addr(line_addr), .line_wdata(line_wdata), .line_rdata(line_rdata),
    .line_ready(line_ready), .line_err(line_err), .line_busy(line_busy),
    .io_addr(io_addr), .io_read(io_read), .io_write(io_write),
    .io_wdata(io_wdata), .io_byte_size(io_byte_size),
    .io_rdata(io_rdata), .io_ready(io_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Responder state
  int          lat = 1;
  logic        var_lat = 1'b0;
  int          no_ack = -1;
  logic [31:0] key = '0;
  logic [31:0] base_exp = '0;
  int          hold_cnt = 0;
  int          hi_cnt_noack = 0;
  int          gap_bad = 0;
  logic        ack_pending = 1'b0;
  int          rd_acks = 0, wr_acks = 0;
  int          ready_cnt = 0;
  logic [31:0] addr_q[$];

  always @(negedge clk) begin
    int word;
    int cur_lat;
    if (line_ready) ready_cnt++;
    if (ack_pending && (io_read || io_write)) gap_bad++;
    ack_pending = 1'b0;
    if (io_read || io_write) begin
      hold_cnt++;
      word    = int'((io_addr - base_exp) >> 2);
      cur_lat = var_lat ? (word % 5) + 1 : lat;
      if (word == no_ack) begin
        hi_cnt_noack++;
        io_ready = 1'b0;
      end else if (hold_cnt >= cur_lat) begin
        io_ready    = 1'b1;
        io_rdata    = io_addr ^ key;
        ack_pending = 1'b1;
        addr_q.push_back(io_addr);
        if (io_write) begin
          wr_acks++;
          chk("io_wdata", io_wdata, 32'(word) * 32'h1111_1111);
        end else begin
          rd_acks++;
        end
      end else begin
        io_ready = 1'b0;
      end
    end else begin
      hold_cnt = 0;
      io_ready = 1'b0;
    end
  end

  task automatic run(input string tag, input logic rd, input logic wr, input logic keep_rd,
                     input logic [31:0] addr, input logic [255:0] wd, output int cyc);
    logic done;
    @(negedge clk);
    line_read_en  = rd;
    line_write_en = wr;
    line_addr     = addr;
    line_wdata    = wd;
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (line_ready) done = 1'b1;
    end
    line_write_en = 1'b0;
    line_read_en  = keep_rd;
    chk({tag, "_done"}, done, 1'b1);
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base, input logic [31:0] k);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = (base + 32'(i * 4)) ^ k;
    return l;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           cyc;
    int           rc0;
    logic         found;
    logic [255:0] exp_line, wline, prev_line;

    rst = 1'b0; line_read_en = 1'b0; line_write_en = 1'b0;
    line_addr = '0; line_wdata = '0; io_rdata = '0; io_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", line_rdata, '0);
    chk("rst_ctrl", {io_read, io_write, line_busy, line_ready, line_err, io_byte_size}, '0);
    chk("rst_io_addr", io_addr, '0);
    rst = 1'b1;

    // T1: read, ack one cycle after strobe, data = address
    base_exp = 32'h8000_0040; key = '0; lat = 1; addr_q.delete(); rc0 = ready_cnt;
    run("rd1", 1, 0, 0, 32'h8000_0040, '0, cyc);
    chk("rd1_err", line_err, 1'b0);
    chk("rd1_cycles", cyc, 17);
    for (int k = 0; k < 8; k++) chk($sformatf("rd1_addr%0d", k), addr_q[k], 32'h8000_0040 + 32'(4 * k));
    chk("rd1_rdata", line_rdata, mk_line(32'h8000_0040, '0));
    @(negedge clk);
    chk("rd1_ready_pulses", ready_cnt - rc0, 1);
    chk("rd1_busy_after", line_busy, 1'b0);

    // T2: write, latency 1..5 per word; line_rdata must not change
    for (int k = 0; k < 8; k++) wline[k*32 +: 32] = 32'(k) * 32'h1111_1111;
    prev_line = line_rdata;
    base_exp = 32'h8000_0100; var_lat = 1'b1; gap_bad = 0; addr_q.delete(); wr_acks = 0;
    run("wr", 0, 1, 0, 32'h8000_0100, wline, cyc);
    var_lat = 1'b0;
    chk("wr_err", line_err, 1'b0);
    chk("wr_acks", wr_acks, 8);
    chk("wr_last_addr", addr_q[7], 32'h8000_011C);
    chk("wr_rdata_kept", line_rdata, mk_line(32'h8000_0040, '0));
    chk("wr_strobe_gap", gap_bad, 0);

    // T3: unaligned line address is forced down to the line boundary
    base_exp = 32'h8000_0040; key = 32'hA5A5_A5A5; addr_q.delete();
    run("align", 1, 0, 0, 32'h8000_005F, '0, cyc);
    chk("align_first_addr", addr_q[0], 32'h8000_0040);
    chk("align_rdata", line_rdata, mk_line(32'h8000_0040, 32'hA5A5_A5A5));

    // T4: both requests high, write goes first, then held read is taken
    base_exp = 32'h8000_0200; key = '0; addr_q.delete(); rd_acks = 0; wr_acks = 0;
    run("both_wr", 1, 1, 1, 32'h8000_0200, wline, cyc);
    chk("both_first_writes", wr_acks, 8);
    chk("both_first_reads", rd_acks, 0);
    run("both_rd", 1, 0, 0, 32'h8000_0200, wline, cyc);
    chk("both_then_reads", rd_acks, 8);
    chk("both_rdata", line_rdata, mk_line(32'h8000_0200, '0));

    // T5: word 3 never acked -> timeout after 255 WAIT cycles
    key = 32'hFFFF_0000; no_ack = 3; hi_cnt_noack = 0;
    run("tmo", 1, 0, 0, 32'h8000_0200, '0, cyc);
    chk("tmo_err", line_err, 1'b1);
    chk("tmo_strobe_cycles", hi_cnt_noack, 255);
    exp_line = mk_line(32'h8000_0200, '0);
    for (int k = 0; k < 3; k++) exp_line[k*32 +: 32] = (32'h8000_0200 + 32'(4 * k)) ^ 32'hFFFF_0000;
    chk("tmo_rdata", line_rdata, exp_line);
    @(negedge clk);
    chk("tmo_err_cleared", {line_err, line_busy, io_read}, 3'b000);
    no_ack = -1; key = '0;

    // T6: reset while word 5 of a read is outstanding
    base_exp = 32'h8000_0300; lat = 2; rc0 = ready_cnt; found = 1'b0;
    @(negedge clk);
    line_read_en = 1'b1; line_addr = 32'h8000_0300;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (io_read && io_addr == 32'h8000_0314) found = 1'b1;
    end
    chk("rst_mid_found", found, 1'b1);
    rst = 1'b0; line_read_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst_mid_ctrl", {io_read, io_write, line_busy, line_ready}, 4'b0000);
    chk("rst_mid_rdata", line_rdata, '0);
    chk("rst_mid_addr", io_addr, '0);
    chk("rst_mid_no_ready", ready_cnt - rc0, 0);
    addr_q.delete();
    run("rst_fresh", 1, 0, 0, 32'h8000_0300, '0, cyc);
    chk("rst_fresh_first", addr_q[0], 32'h8000_0300);
    chk("rst_fresh_err", line_err, 1'b0);
    chk("rst_fresh_rdata", line_rdata, mk_line(32'h8000_0300, '0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
